ic_7458_seq: RTL and testbench
==============================

IC_7458_SEQ -- requirements
Module: ic_7458_seq

Interface
REQ-001 Parameter SETTLE_CYC, default 1: cycles a vector is held before the DUT output is sampled; legal range 1..15.
REQ-002 Parameter LAST_VEC, default 1023: final vector index of the sweep; legal range 0..1023.
REQ-003 clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  begin a sweep; sampled only in IDLE or DONE.
REQ-006 abort  in  1  cancel a running sweep.
REQ-007 stim_p1  out  6  drives 7458 section 1 inputs; bit0..5 = p1a..p1f.
REQ-008 stim_p2  out  4  drives 7458 section 2 inputs; bit0..3 = p2a..p2d.
REQ-009 dut_p1y  in  1  7458 section 1 output.
REQ-010 dut_p2y  in  1  7458 section 2 output.
REQ-011 busy  out  1  high while in SETTLE or CHECK.
REQ-012 done  out  1  one-cycle pulse on sweep completion.
REQ-013 pass  out  1  high when the last completed sweep had zero mismatches; held until the next start.
REQ-014 err_cnt  out  11  number of mismatching vectors in the current or last sweep.
REQ-015 first_err_vec  out  10  index of the first mismatching vector.
REQ-016 first_err_valid  out  1  first_err_vec holds a captured index.

Function
REQ-017 The block SHALL hold an internal 10-bit vector counter vec; {stim_p2, stim_p1} SHALL equal vec at all times.
REQ-018 The FSM SHALL have exactly four states: IDLE, SETTLE, CHECK and DONE.
REQ-019 IDLE or DONE with start=1: vec<=0, err_cnt<=0, first_err_valid<=0, pass<=0, settle counter<=0, next state SETTLE.
REQ-020 SETTLE: the settle counter SHALL increment each cycle, and the FSM SHALL move to CHECK on the cycle the counter reaches SETTLE_CYC-1.
REQ-021 CHECK, one cycle: expected p1y = (a&b&c)|(d&e&f) from stim_p1; expected p2y = (a&b)|(c&d) from stim_p2; mismatch = either DUT output differs from its expected value.
REQ-022 On a mismatch in CHECK, err_cnt SHALL increment; if first_err_valid=0, first_err_vec<=vec and first_err_valid<=1.
REQ-023 CHECK with vec!=LAST_VEC: vec<=vec+1, settle counter<=0, next state SETTLE.
REQ-024 CHECK with vec==LAST_VEC: vec holds, next state DONE.
REQ-025 On entering DONE the block SHALL pulse done for one cycle and set pass<=1 when the final err_cnt (including the last CHECK) is 0.
REQ-026 DONE SHALL hold and wait for start; vec and the result outputs SHALL stay unchanged.
REQ-027 Each vector SHALL take SETTLE_CYC+1 cycles, giving a full sweep of (LAST_VEC+1)*(SETTLE_CYC+1) cycles from the start cycle to the cycle before done.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort while busy SHALL force IDLE on the next cycle: no done pulse, pass=0, err_cnt and first_err_* held, and a CHECK in that same cycle SHALL NOT update counters.
REQ-030 abort and start together in IDLE or DONE: start wins.
REQ-031 abort in IDLE or DONE SHALL have no effect.
REQ-032 err_cnt SHALL NOT wrap; its maximum value is 1024.

Reset
REQ-033 rst=1 SHALL force IDLE, vec=0 (stim_p1=0, stim_p2=0), busy=0, done=0, pass=0, err_cnt=0, first_err_vec=0 and first_err_valid=0 on the next edge.
REQ-034 rst SHALL have priority over start and abort.
REQ-035 rst asserted mid-sweep SHALL discard all progress, and no done pulse SHALL follow.

Verification
REQ-036 Correct 7458 model, defaults, start pulse -> done exactly 2048 cycles after the start cycle; pass=1, err_cnt=0, first_err_valid=0.
REQ-037 dut_p1y stuck at 0 -> err_cnt=240, first_err_vec=7, pass=0.
REQ-038 dut_p2y stuck at 1 -> err_cnt=576, first_err_vec=0, pass=0.
REQ-039 abort at vec=100 -> next cycle IDLE, busy=0, no done pulse; a restart then clears err_cnt and completes with pass=1.
REQ-040 rst mid-sweep, then start held high throughout a sweep -> outputs cleared; second start ignored while busy; a single sweep completes; done pulses once.
REQ-041 SETTLE_CYC=3, LAST_VEC=15, correct model -> done after 64 cycles; stim stable for 4 cycles per vector; pass=1.

Source files
------------

// File: rtl/ic_7458_seq_if.sv
// ic_7458_seq_if
// Groups the control handshake, the stimulus bus driven to the 7458 under
// test, the 7458 outputs coming back and the sweep result signals.
//   master : the controller/fixture side (issues start/abort, returns the
//            7458 outputs, observes results)
//   slave  : the sweep sequencer (ic_7458_seq)
interface ic_7458_seq_if;
    logic        start;
    logic        abort;
    logic [5:0]  stim_p1;
    logic [3:0]  stim_p2;
    logic        dut_p1y;
    logic        dut_p2y;
    logic        busy;
    logic        done;
    logic        pass;
    logic [10:0] err_cnt;
    logic [9:0]  first_err_vec;
    logic        first_err_valid;

    modport master (
        output start, abort, dut_p1y, dut_p2y,
        input  stim_p1, stim_p2, busy, done, pass,
               err_cnt, first_err_vec, first_err_valid
    );

    modport slave (
        input  start, abort, dut_p1y, dut_p2y,
        output stim_p1, stim_p2, busy, done, pass,
               err_cnt, first_err_vec, first_err_valid
    );
endinterface

// File: rtl/ic_7458_seq.sv
// ic_7458_seq
// Exhaustive functional tester for a 7458 (dual AND-OR) device. A 10-bit
// vector counter is swept from 0 to LAST_VEC and presented on the stimulus
// bus; each vector is held SETTLE_CYC cycles and then the device outputs are
// compared against the ideal 7458 function for one cycle.
// Ports:
//   clk   - single clock, rising edge
//   rst   - synchronous active-high reset
//   bus   - ic_7458_seq_if.slave: start/abort in, stim_p1/stim_p2 out,
//           dut_p1y/dut_p2y in, busy/done/pass/err_cnt/first_err_* out
// Parameters:
//   SETTLE_CYC - hold cycles per vector before checking (1..15)
//   LAST_VEC   - final vector index of the sweep (0..1023)
module ic_7458_seq #(
    parameter int SETTLE_CYC = 1,
    parameter int LAST_VEC   = 1023
) (
    input logic         clk,
    input logic         rst,
    ic_7458_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [9:0]  LAST_IDX    = 10'(LAST_VEC);
    localparam logic [10:0] ERR_MAX     = 11'd1024;

    state_t      state;
    logic [9:0]  vec;
    logic [3:0]  settle_cnt;
    logic [10:0] err_cnt;
    logic [9:0]  first_err_vec;
    logic        first_err_valid;
    logic        pass;
    logic        done;

    logic        exp_p1y;
    logic        exp_p2y;
    logic        mismatch;

    // The stimulus bus is the vector counter itself: the low six bits feed
    // section 1 (p1a..p1f) and the upper four bits feed section 2 (p2a..p2d).
    // Ideal 7458 responses are derived from the same bits so the expected
    // values always match what is currently driven.
    assign exp_p1y  = (vec[0] & vec[1] & vec[2]) | (vec[3] & vec[4] & vec[5]);
    assign exp_p2y  = (vec[6] & vec[7]) | (vec[8] & vec[9]);
    assign mismatch = (bus.dut_p1y != exp_p1y) || (bus.dut_p2y != exp_p2y);

    assign bus.stim_p1         = vec[5:0];
    assign bus.stim_p2         = vec[9:6];
    assign bus.busy            = (state == SETTLE) || (state == CHECK);
    assign bus.done            = done;
    assign bus.pass            = pass;
    assign bus.err_cnt         = err_cnt;
    assign bus.first_err_vec   = first_err_vec;
    assign bus.first_err_valid = first_err_valid;

    // Sweep sequencer. IDLE and DONE both wait for start; a start clears the
    // results and begins at vector 0. SETTLE counts hold cycles, CHECK samples
    // the device for exactly one cycle and either advances to the next vector
    // or finishes. Abort while busy returns to IDLE without touching the
    // result counters, even when it lands on a CHECK cycle. done is a
    // registered single-cycle pulse raised on the CHECK->DONE transition, and
    // pass folds in the verdict of that final CHECK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            vec             <= '0;
            settle_cnt      <= '0;
            err_cnt         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        vec             <= '0;
                        err_cnt         <= '0;
                        first_err_valid <= 1'b0;
                        pass            <= 1'b0;
                        settle_cnt      <= '0;
                        state           <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (bus.abort) begin
                        pass  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (bus.abort) begin
                        pass  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (mismatch) begin
                            if (err_cnt != ERR_MAX) begin
                                err_cnt <= err_cnt + 11'd1;
                            end
                            if (!first_err_valid) begin
                                first_err_vec   <= vec;
                                first_err_valid <= 1'b1;
                            end
                        end
                        if (vec == LAST_IDX) begin
                            done  <= 1'b1;
                            pass  <= (err_cnt == 11'd0) && !mismatch;
                            state <= DONE;
                        end else begin
                            vec        <= vec + 10'd1;
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ic_7458_seq.sv
// tb_ic_7458_seq
// Drives two sequencers (default parameters, and SETTLE_CYC=3/LAST_VEC=15)
// against a behavioural 7458 with selectable faults. Each requested sweep
// pushes a predicted result into a per-instance queue; a monitor pops and
// compares whenever a done pulse appears.
module tb_ic_7458_seq;

    typedef struct {
        int errs;
        int fvec;
        int fvalid;
        int pass;
    } exp_t;

    logic clk;
    logic rst;

    ic_7458_seq_if bus0 ();
    ic_7458_seq_if bus1 ();

    logic [1:0] startv;
    logic [1:0] abortv;
    logic [1:0] mode [2];
    int         badA [2];
    int         badB [2];

    logic [1:0] donev;
    logic [1:0] busyv;
    logic [1:0] passv;
    logic [1:0] fvalv;
    logic [10:0] errv [2];
    logic [9:0]  fvecv [2];
    logic [9:0]  stimv [2];
    logic [1:0]  chip0;
    logic [1:0]  chip1;

    exp_t q0 [$];
    exp_t q1 [$];

    int vectors;
    int miscompares;

    ic_7458_seq dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    ic_7458_seq #(
        .SETTLE_CYC (3),
        .LAST_VEC   (15)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 7458 with fault injection: mode 0 healthy, 1 = p1y stuck
    // at 0, 2 = p2y stuck at 1, 3 = p1y inverted at vector ba and p2y
    // inverted at vector bb.
    function automatic logic [1:0] chip(input logic [5:0] p1, input logic [3:0] p2,
                                        input logic [1:0] m, input int ba, input int bb);
        logic y1;
        logic y2;
        int   idx;
        idx = int'({p2, p1});
        y1  = (p1[0] & p1[1] & p1[2]) | (p1[3] & p1[4] & p1[5]);
        y2  = (p2[0] & p2[1]) | (p2[2] & p2[3]);
        if (m == 2'd1) y1 = 1'b0;
        if (m == 2'd2) y2 = 1'b1;
        if (m == 2'd3 && idx == ba) y1 = ~y1;
        if (m == 2'd3 && idx == bb) y2 = ~y2;
        return {y2, y1};
    endfunction

    assign chip0 = chip(bus0.stim_p1, bus0.stim_p2, mode[0], badA[0], badB[0]);
    assign chip1 = chip(bus1.stim_p1, bus1.stim_p2, mode[1], badA[1], badB[1]);

    assign bus0.start   = startv[0];
    assign bus1.start   = startv[1];
    assign bus0.abort   = abortv[0];
    assign bus1.abort   = abortv[1];
    assign bus0.dut_p1y = chip0[0];
    assign bus0.dut_p2y = chip0[1];
    assign bus1.dut_p1y = chip1[0];
    assign bus1.dut_p2y = chip1[1];

    assign donev    = {bus1.done, bus0.done};
    assign busyv    = {bus1.busy, bus0.busy};
    assign passv    = {bus1.pass, bus0.pass};
    assign fvalv    = {bus1.first_err_valid, bus0.first_err_valid};
    assign errv[0]  = bus0.err_cnt;
    assign errv[1]  = bus1.err_cnt;
    assign fvecv[0] = bus0.first_err_vec;
    assign fvecv[1] = bus1.first_err_vec;
    assign stimv[0] = {bus0.stim_p2, bus0.stim_p1};
    assign stimv[1] = {bus1.stim_p2, bus1.stim_p1};

    // Reference: walk every vector index, decide from the fault description
    // whether the device answer disagrees with an ideal 7458, and summarise.
    function automatic exp_t predict(input int last, input logic [1:0] m,
                                     input int ba, input int bb);
        exp_t r;
        bit   e1;
        bit   e2;
        bit   bad;
        r = '{errs: 0, fvec: 0, fvalid: 0, pass: 0};
        for (int i = 0; i <= last; i++) begin
            e1  = ((i & 7) == 7) || (((i >> 3) & 7) == 7);
            e2  = (((i >> 6) & 3) == 3) || (((i >> 8) & 3) == 3);
            bad = (m == 2'd1 && e1) || (m == 2'd2 && !e2) ||
                  (m == 2'd3 && (i == ba || i == bb));
            if (bad) begin
                if (r.fvalid == 0) begin
                    r.fvec   = i;
                    r.fvalid = 1;
                end
                r.errs++;
            end
        end
        r.pass = (r.errs == 0) ? 1 : 0;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Select the device fault, optionally queue the predicted result, and
    // pulse start for one cycle. Returns #1 after the edge that sampled start.
    task automatic applyStimulus(input int k, input logic [1:0] m, input int ba,
                                 input int bb, input bit expect_result);
        exp_t e;
        mode[k] = m;
        badA[k] = ba;
        badB[k] = bb;
        if (expect_result) begin
            e = predict((k == 0) ? 1023 : 15, m, ba, bb);
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        startv[k] = 1'b1;
        @(posedge clk);
        #1;
        startv[k] = 1'b0;
    endtask

    task automatic waitDone(input int k, input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (donev[k]) break;
        end
        if (!donev[k]) checkOutput("done timeout", cyc, -1);
    endtask

    task automatic scoreCheck(input int k);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (k == 0 && q0.size() > 0) begin
            e    = q0.pop_front();
            have = 1'b1;
        end
        if (k == 1 && q1.size() > 0) begin
            e    = q1.pop_front();
            have = 1'b1;
        end
        if (!have) begin
            checkOutput("unexpected done pulse", k, -1);
        end else begin
            checkOutput("sb err_cnt", int'(errv[k]), e.errs);
            checkOutput("sb first_err_valid", int'(fvalv[k]), e.fvalid);
            checkOutput("sb pass", int'(passv[k]), e.pass);
            if (e.fvalid != 0) checkOutput("sb first_err_vec", int'(fvecv[k]), e.fvec);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge away from updates.
    always @(negedge clk) begin
        if (donev[0]) scoreCheck(0);
        if (donev[1]) scoreCheck(1);
    end

    initial begin
        int cyc;
        int runLen;
        int ba;
        logic [9:0] prev;

        vectors     = 0;
        miscompares = 0;
        startv      = 2'b00;
        abortv      = 2'b00;
        for (int k = 0; k < 2; k++) begin
            mode[k] = 2'd0;
            badA[k] = -1;
            badB[k] = -1;
        end

        // Reset with start and abort asserted: reset must dominate.
        rst    = 1'b1;
        startv = 2'b11;
        abortv = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset busy", int'(busyv[k]), 0);
            checkOutput("reset done", int'(donev[k]), 0);
            checkOutput("reset pass", int'(passv[k]), 0);
            checkOutput("reset err_cnt", int'(errv[k]), 0);
            checkOutput("reset first_err_vec", int'(fvecv[k]), 0);
            checkOutput("reset first_err_valid", int'(fvalv[k]), 0);
            checkOutput("reset stim", int'(stimv[k]), 0);
        end
        rst    = 1'b0;
        startv = 2'b00;
        abortv = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        // Healthy device: full sweep length and clean result.
        applyStimulus(0, 2'd0, -1, -1, 1'b1);
        waitDone(0, 2100, cyc);
        checkOutput("sweep length", cyc, 2048);

        // p1y stuck at 0, then abort in DONE must leave results alone.
        applyStimulus(0, 2'd1, -1, -1, 1'b1);
        waitDone(0, 2100, cyc);
        checkOutput("p1y stuck err_cnt", int'(errv[0]), 240);
        checkOutput("p1y stuck first_err_vec", int'(fvecv[0]), 7);
        checkOutput("p1y stuck pass", int'(passv[0]), 0);
        @(negedge clk);
        abortv[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        abortv[0] = 1'b0;
        checkOutput("abort in DONE err_cnt", int'(errv[0]), 240);
        checkOutput("abort in DONE busy", int'(busyv[0]), 0);

        // p2y stuck at 1.
        applyStimulus(0, 2'd2, -1, -1, 1'b1);
        waitDone(0, 2100, cyc);
        checkOutput("p2y stuck err_cnt", int'(errv[0]), 576);
        checkOutput("p2y stuck first_err_vec", int'(fvecv[0]), 0);
        checkOutput("p2y stuck pass", int'(passv[0]), 0);

        // Random isolated faults, including the final vector sometimes.
        for (int n = 0; n < 2; n++) begin
            applyStimulus(0, 2'd3, int'($urandom_range(1023, 0)),
                          (n == 1) ? 1023 : int'($urandom_range(1023, 0)), 1'b1);
            waitDone(0, 2100, cyc);
        end

        // Abort at vector 100 after one injected error below it.
        ba = int'($urandom_range(99, 0));
        applyStimulus(0, 2'd3, ba, ba, 1'b0);
        cyc = 0;
        while (cyc < 400 && stimv[0] != 10'd100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("reach vec 100", int'(stimv[0]), 100);
        abortv[0] = 1'b1;
        @(posedge clk);
        #1;
        abortv[0] = 1'b0;
        checkOutput("abort busy", int'(busyv[0]), 0);
        checkOutput("abort pass", int'(passv[0]), 0);
        checkOutput("abort err_cnt held", int'(errv[0]), 1);
        checkOutput("abort first_err_vec held", int'(fvecv[0]), ba);
        checkOutput("abort first_err_valid held", int'(fvalv[0]), 1);
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(0, 2'd0, -1, -1, 1'b1);
        waitDone(0, 2100, cyc);
        checkOutput("restart sweep length", cyc, 2048);

        // Reset mid-sweep, then a sweep with start held high throughout.
        applyStimulus(0, 2'd1, -1, -1, 1'b0);
        repeat (int'($urandom_range(900, 300))) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid reset busy", int'(busyv[0]), 0);
        checkOutput("mid reset err_cnt", int'(errv[0]), 0);
        checkOutput("mid reset first_err_valid", int'(fvalv[0]), 0);
        checkOutput("mid reset stim", int'(stimv[0]), 0);
        mode[0] = 2'd0;
        q0.push_back(predict(1023, 2'd0, -1, -1));
        @(negedge clk);
        startv[0] = 1'b1;
        @(posedge clk);
        #1;
        waitDone(0, 2100, cyc);
        startv[0] = 1'b0;
        checkOutput("held start sweep length", cyc, 2048);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("no restart after done", int'(busyv[0]), 0);

        // Small instance: per-vector hold time and sweep length.
        applyStimulus(1, 2'd0, -1, -1, 1'b1);
        prev   = stimv[1];
        runLen = 1;
        cyc    = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (donev[1]) break;
            if (stimv[1] == prev) begin
                runLen++;
            end else begin
                checkOutput("stim hold cycles", runLen, 4);
                prev   = stimv[1];
                runLen = 1;
            end
        end
        checkOutput("small sweep done seen", int'(donev[1]), 1);
        checkOutput("last stim hold cycles", runLen, 4);
        checkOutput("small sweep length", cyc, 64);

        // Small instance: random fault mixes through the scoreboard.
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1, 2'($urandom_range(3, 0)), int'($urandom_range(15, 0)),
                          int'($urandom_range(15, 0)), 1'b1);
            waitDone(1, 80, cyc);
            checkOutput("random small sweep length", cyc, 64);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard 0 drained", q0.size(), 0);
        checkOutput("scoreboard 1 drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
